// File: rtl/ahb_lite_master.sv
// ahb_lite_master: turns a valid/ready command stream into single NONSEQ AHB-Lite transfers.
// Latency: accept at edge N, address phase after N, data phase after N+1, rsp_valid after N+2 (plus wait states).
// Backpressure: cmd_ready follows HREADY directly; responses cannot be stalled.
//
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   cmd_*                 command stream (write, byte address, size, right-aligned write data)
//   rsp_*                 one-cycle completion pulse with direction, read data and error flag
//   busy                  address or data phase outstanding
//   H*                    AHB-Lite master signals (address phase, write data, slave response)
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic        w_accept;
    logic [1:0]  w_size;
    logic [31:0] w_addr_aligned;
    logic [31:0] w_wdata_rep;

    logic [31:0] r_haddr;
    logic [1:0]  r_htrans;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [31:0] r_hwdata;
    logic [31:0] r_wdata_q;     // lane-replicated write data waiting for its data phase
    logic        r_dp_valid;    // a transfer occupies the data phase
    logic        r_dp_write;
    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;

    // A stalled bus freezes every pipeline stage, so nothing new can be taken.
    assign cmd_ready = HREADY;
    assign w_accept  = cmd_valid & HREADY;

    // Size 3 has no meaning on a 32-bit bus; treat it as a word.
    assign w_size = (cmd_size == 2'd3) ? 2'd2 : cmd_size;

    // Align the address to the transfer size and copy the data onto every
    // lane so the slave finds it on whichever byte lanes HADDR selects.
    always_comb begin
        w_addr_aligned = cmd_addr;
        w_wdata_rep    = cmd_wdata;
        case (w_size)
            2'd0: begin
                w_wdata_rep = {4{cmd_wdata[7:0]}};
            end
            2'd1: begin
                w_addr_aligned = {cmd_addr[31:1], 1'b0};
                w_wdata_rep    = {2{cmd_wdata[15:0]}};
            end
            default: begin
                w_addr_aligned = {cmd_addr[31:2], 2'b00};
            end
        endcase
    end

    // Address phase, data phase and completion all advance on the same
    // HREADY edge, which is what sustains one transfer per cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_haddr     <= '0;
            r_htrans    <= TRANS_IDLE;
            r_hwrite    <= 1'b0;
            r_hsize     <= '0;
            r_hwdata    <= '0;
            r_wdata_q   <= '0;
            r_dp_valid  <= 1'b0;
            r_dp_write  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= HREADY & r_dp_valid;
            if (HREADY) begin
                // Address phase: on idle cycles only HTRANS changes.
                if (w_accept) begin
                    r_htrans  <= TRANS_NONSEQ;
                    r_haddr   <= w_addr_aligned;
                    r_hwrite  <= cmd_write;
                    r_hsize   <= {1'b0, w_size};
                    r_wdata_q <= w_wdata_rep;
                end else begin
                    r_htrans  <= TRANS_IDLE;
                end

                // Address phase moves into the data phase.
                r_dp_valid <= (r_htrans == TRANS_NONSEQ);
                r_dp_write <= r_hwrite;
                if ((r_htrans == TRANS_NONSEQ) && r_hwrite) begin
                    r_hwdata <= r_wdata_q;
                end

                // Data phase completes.
                if (r_dp_valid) begin
                    r_rsp_write <= r_dp_write;
                    r_rsp_error <= HRESP;
                    r_rsp_rdata <= r_dp_write ? 32'd0 : HRDATA;
                end
            end
        end
    end

    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HWDATA    = r_hwdata;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign busy      = (r_htrans == TRANS_NONSEQ) | r_dp_valid;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: scoreboard bench for ahb_lite_master with a behavioural AHB slave.
// Expected bus and response values come from the command alone (alignment, lane copy, slave data rule).
// Slave wait states are chosen per command by the driver and applied by the slave model.
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [1:0]  cmd_size = 2'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = 32'd0;
    logic        HRESP = 1'b0;

    ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          waits;
    } aexp_t;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic        error;
        int          cyc;
    } rexp_t;

    aexp_t aq[$];
    rexp_t rq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit zw = 1'b0;

    // slave model state
    bit          s_act = 1'b0;
    bit          s_write = 1'b0;
    bit          s_err = 1'b0;
    logic [31:0] s_addr = 32'd0;
    logic [31:0] s_wdata = 32'd0;
    int          s_left = 0;
    bit          last_stalled = 1'b0;

    // monitor stability snapshot
    bit          have_prev = 1'b0;
    logic [31:0] p_haddr, p_hwdata;
    logic [1:0]  p_htrans;
    logic        p_hwrite;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    endtask

    // Slave: captures address phases, checks them against the expected queue,
    // and answers each data phase with the per-command wait count. Read data
    // is address+0x100; any address in 0xDEADxxxx gets a two-cycle ERROR.
    always @(posedge HCLK) begin
        aexp_t e;
        cyc = cyc;
        if (!HRESETn) begin
            s_act = 1'b0;
            last_stalled = 1'b0;
            #1;
            HREADY = 1'b1;
            HRESP  = 1'b0;
            HRDATA = $urandom;
        end else begin
            last_stalled = !HREADY;
            if (HREADY) begin
                if (s_act && s_write) chk("hwdata", HWDATA, s_wdata);
                s_act = 1'b0;
                if (HTRANS == 2'b10) begin
                    if (aq.size() == 0) begin
                        fail_now("unexpected_addr_phase", 1, 0);
                    end else begin
                        e = aq.pop_front();
                        chk("haddr", HADDR, e.addr);
                        chk("hwrite", 32'(HWRITE), 32'(e.write));
                        chk("hsize", 32'(HSIZE), 32'(e.size));
                        s_act   = 1'b1;
                        s_write = HWRITE;
                        s_addr  = HADDR;
                        s_err   = (HADDR[31:16] == 16'hDEAD);
                        s_wdata = e.wdata;
                        s_left  = s_err ? 1 : e.waits;
                    end
                end
            end else if (s_left > 0) begin
                s_left--;
            end
            #1;
            if (s_act) begin
                HREADY = (s_left == 0);
                HRESP  = s_err;
                HRDATA = s_addr + 32'h100;
            end else begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
                HRDATA = $urandom;
            end
        end
    end

    // Monitor: sampled on the falling edge. Pops the response scoreboard on
    // every rsp_valid and checks handshake, busy and wait-state stability.
    always @(negedge HCLK) begin
        rexp_t r;
        cyc++;
        if (HRESETn) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(HREADY));
            chk("busy", 32'(busy), 32'((aq.size() != 0) || s_act));
            if (last_stalled && have_prev) begin
                chk("stall_haddr", HADDR, p_haddr);
                chk("stall_htrans", 32'(HTRANS), 32'(p_htrans));
                chk("stall_hwrite", 32'(HWRITE), 32'(p_hwrite));
                chk("stall_hwdata", HWDATA, p_hwdata);
            end
            p_haddr = HADDR; p_htrans = HTRANS; p_hwrite = HWRITE; p_hwdata = HWDATA;
            have_prev = 1'b1;
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    fail_now("unexpected_rsp", 1, 0);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_write", 32'(rsp_write), 32'(r.write));
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_error", 32'(rsp_error), 32'(r.error));
                    if (r.cyc >= 0) chk("rsp_latency", 32'(cyc), 32'(r.cyc));
                end
            end
        end else begin
            have_prev = 1'b0;
        end
    end

    // Issue one command; expectations are pushed at the accepting edge.
    task automatic send(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] d, input int waits);
        aexp_t e;
        rexp_t r;
        int    sb;
        int    nb;
        int    t;
        logic [31:0] al;
        sb = (sz == 2'd3) ? 2 : int'(sz);
        nb = 1 << sb;
        al = a - (a % 32'(nb));
        e.addr  = al;
        e.write = w;
        e.size  = 3'(sb);
        e.wdata = (sb == 0) ? (d & 32'hFF) * 32'h01010101 :
                  (sb == 1) ? (d & 32'hFFFF) * 32'h00010001 : d;
        e.waits = waits;
        r.write = w;
        r.rdata = w ? 32'd0 : al + 32'h100;
        r.error = (al[31:16] == 16'hDEAD);
        r.cyc   = -1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_wdata = d;
        t = 0;
        do begin
            @(posedge HCLK);
            t++;
        end while (!cmd_ready && t < 100);
        if (!cmd_ready) begin
            fail_now("accept_timeout", t, 1);
        end else begin
            if (zw) r.cyc = cyc + 3;
            aq.push_back(e);
            rq.push_back(r);
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (rq.size() != 0 && t < 200) begin
            @(negedge HCLK);
            t++;
        end
        checks++;
        if (rq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", rq.size());
        end
        repeat (2) @(negedge HCLK);
    endtask

    initial begin
        logic [31:0] a;
        // reset values
        repeat (3) @(negedge HCLK);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("hburst", 32'(HBURST), 32'd0);
        chk("hprot", 32'(HPROT), 32'h3);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // single zero-wait write with explicit phase timing
        zw = 1'b1;
        send(1'b1, 32'h5000_0000, 2'd2, 32'h0000_00A5, 0);
        @(negedge HCLK);
        chk("t1_htrans", 32'(HTRANS), 32'h2);
        chk("t1_haddr", HADDR, 32'h5000_0000);
        chk("t1_hwrite", 32'(HWRITE), 32'd1);
        @(negedge HCLK);
        chk("t1_hwdata", HWDATA, 32'h0000_00A5);
        @(negedge HCLK);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_error", 32'(rsp_error), 32'd0);
        drain();

        // back-to-back reads, one per cycle
        for (int i = 0; i < 4; i++) send(1'b0, 32'(i * 4), 2'd2, 32'd0, 0);
        drain();
        zw = 1'b0;

        // wait states on a write
        send(1'b1, 32'h6000_0010, 2'd2, 32'hCAFE_F00D, 3);
        drain();

        // error read with a write queued behind it
        send(1'b0, 32'hDEAD_0000, 2'd2, 32'd0, 0);
        send(1'b1, 32'h7000_0004, 2'd2, 32'h1122_3344, 0);
        drain();

        // size and alignment
        send(1'b1, 32'h0000_0013, 2'd0, 32'h0000_005A, 0);
        send(1'b1, 32'h0000_0013, 2'd1, 32'h0000_1234, 0);
        drain();

        // reset during a waited data phase
        send(1'b1, 32'h8000_0000, 2'd2, 32'h0000_0055, 6);
        repeat (3) @(negedge HCLK);
        #1;
        HRESETn = 1'b0;
        aq.delete();
        rq.delete();
        #1;
        chk("mid_rst_htrans", 32'(HTRANS), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_haddr", HADDR, 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (5) @(negedge HCLK);
        send(1'b0, 32'h0000_0040, 2'd2, 32'd0, 1);
        drain();

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            if ($urandom_range(7) == 0) a[31:16] = 16'hDEAD;
            send(1'($urandom_range(1)), a, 2'($urandom_range(3)), $urandom, int'($urandom_range(2)));
            if ($urandom_range(3) == 0) repeat ($urandom_range(2) + 1) @(negedge HCLK);
        end
        drain();

        chk("aq_empty", 32'(aq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- AHB-Lite initiator that turns a simple valid/ready command stream into single NONSEQ AHB-Lite transfers (HBURST=SINGLE).
- Drives the bus as master for the system's memory-mapped peripherals. Lets a local engine (DMA, test sequencer, debug bridge) read and write slaves without the CPU.
- Fully pipelined: the next command's address phase overlaps the current data phase, so back-to-back zero-wait transfers reach one transfer per cycle.

Parameters:
- HPROT_VAL, 4'b0011, constant value driven on HPROT (non-cacheable, non-bufferable, privileged, data).

Ports:
- HCLK  input  1  system clock, all state on rising edge
- HRESETn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted at rising edge when cmd_valid & cmd_ready
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  32  byte address
- cmd_size  input  2  0=byte, 1=halfword, 2=word, 3 coerced to word
- cmd_wdata  input  32  write data, right-aligned (value in low bits)
- rsp_valid  output  1  one-cycle pulse, a data phase completed
- rsp_write  output  1  direction of the completed transfer
- rsp_rdata  output  32  HRDATA sampled at completion (raw lanes; 0 for writes)
- rsp_error  output  1  HRESP was ERROR at completion
- busy  output  1  address or data phase outstanding
- HADDR  output  32  AHB address
- HTRANS  output  2  IDLE (2'b00) or NONSEQ (2'b10) only
- HWRITE  output  1  AHB direction
- HSIZE  output  3  {1'b0, size}
- HBURST  output  3  constant 3'b000
- HPROT  output  4  constant HPROT_VAL
- HWDATA  output  32  data-phase write data
- HREADY  input  1  bus ready (slave HREADYOUT after mux)
- HRDATA  input  32  read data
- HRESP  input  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async, HRESETn=0) sets:
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0
  - rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_error=0
  - internal data-phase flag dp_valid=0, busy=0
- Reset mid-transfer drops the transfer with no response. Outputs return to reset values immediately.
- cmd_ready = HREADY (combinational). No command is taken while the bus is stalled.
- All AHB outputs are registered and update only on an edge where HREADY=1. They are held stable during wait states.
- Address phase, on an edge with HREADY=1:
  - If a command is accepted: HTRANS<=NONSEQ, HWRITE<=cmd_write, HSIZE<={1'b0,size'}.
  - HADDR<=cmd_addr with low bits forced aligned: byte none, halfword bit0=0, word bits[1:0]=0.
  - wdata_q<=cmd_wdata replicated to all lanes: byte {4{b}}, halfword {2{h}}, word as-is.
  - If no command is accepted: HTRANS<=IDLE; HADDR/HWRITE/HSIZE keep their last value.
- Data phase, on an edge with HREADY=1:
  - dp_valid<=(HTRANS==NONSEQ), dp_write<=HWRITE.
  - HWDATA<=wdata_q when HTRANS==NONSEQ and HWRITE=1; otherwise HWDATA is held.
- Completion, on an edge with HREADY=1 and dp_valid=1:
  - rsp_valid<=1, rsp_write<=dp_write, rsp_error<=HRESP.
  - rsp_rdata<=dp_write ? 0 : HRDATA.
  - rsp_valid deasserts next cycle unless another completion occurs. There is no response backpressure.
- Latency (zero-wait slave): command accepted at edge N → address phase cycle N+1 → data phase N+2 → rsp_valid high in the cycle after edge N+2.
  - Each wait state adds one cycle.
- Error response: first cycle HRESP=1/HREADY=0 is a wait state. Second cycle HRESP=1/HREADY=1 completes with rsp_error=1.
  - The pipelined next address phase is NOT cancelled and proceeds normally.
- busy = (HTRANS==NONSEQ) | dp_valid.
- Simultaneous events: on one HREADY=1 edge, a new accept, an address→data move and a completion all occur together. This is required for full throughput.
- Responses are returned strictly in command order.

Test Plan:
- Single write, zero-wait slave: cmd write addr 0x5000_0000, size word, data 0x0000_00A5 → HTRANS=NONSEQ/HADDR=0x5000_0000/HWRITE=1 next cycle; HWDATA=0x0000_00A5 the cycle after; rsp_valid pulse with rsp_error=0.
- Back-to-back: 4 reads to 0x0,0x4,0x8,0xC with slave returning addr+0x100 → NONSEQ on 4 consecutive cycles; 4 consecutive rsp_valid pulses with rdata 0x100,0x104,0x108,0x10C in order.
- Wait states: slave holds HREADY=0 for 3 cycles on a write → cmd_ready=0 and HADDR/HTRANS/HWDATA stable throughout; single rsp_valid after HREADY returns.
- Error: two-cycle ERROR response to a read of 0xDEAD_0000, with a write queued behind it → rsp_error=1 on the read; the following write completes OKAY with rsp_error=0.
- Size/alignment: byte write addr 0x13 data 0x5A, then halfword write addr 0x13 data 0x1234 → HADDR=0x13, HSIZE=0, HWDATA=0x5A5A5A5A; then HADDR=0x12, HSIZE=1, HWDATA=0x12341234.
- Reset mid-operation: assert HRESETn=0 during a waited data phase → HTRANS=IDLE and busy=0 immediately; no rsp_valid after release; the next command behaves normally.
